// File: rtl/mips_fetch_pkg.sv
// Shared types for the MIPS instruction-fetch front end: FSM encoding,
// reset PC default and the prefetch FIFO entry layout.
package mips_fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FLUSH = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Saturating 32-bit accumulate used by the optional performance counters.
    function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {pc, instr} pairs; push/pop/flush with a live count.
// Push while full is accepted only when a pop happens in the same cycle.
module fetch_fifo
    import mips_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  fetch_entry_t                 data_i,
    output fetch_entry_t                 data_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign data_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer/count state; a flush discards everything including a same-cycle push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/mips_fetch_unit.sv
// Instruction-fetch front end: credit-limited imem requests, prefetch FIFO,
// redirect flush with stale-response dropping. FETCH_PERF_EN adds perf counters.
module mips_fetch_unit
    import mips_fetch_pkg::*;
#(
    parameter int unsigned     FIFO_DEPTH = 4,
    parameter logic [XLEN-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            fetch_enable,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_instr,
    output logic [XLEN-1:0] out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_dropped,
    output logic [31:0]     perf_stall
`endif
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned SW = CW + 1;

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

    logic            resp_fire;
    logic            resp_drop;
    logic            req_fire;
    logic            credit_ok;

    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_flush;
    fetch_entry_t    fifo_wdata;
    fetch_entry_t    fifo_rdata;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clock),
        .rst_n   (reset_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .data_i  (fifo_wdata),
        .data_o  (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign imem_req_addr = fetch_pc_q;
    assign out_valid     = !fifo_empty;
    assign out_instr     = out_valid ? fifo_rdata.instr : '0;
    assign out_pc        = out_valid ? fifo_rdata.pc    : '0;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Issue, response steering, redirect handling and next state.
    always_comb begin
        state_d        = state_q;
        fetch_pc_d     = fetch_pc_q;
        resp_pc_d      = resp_pc_q;
        outstanding_d  = outstanding_q;
        drop_cnt_d     = drop_cnt_q;
        fifo_push      = 1'b0;
        fifo_pop       = 1'b0;
        fifo_flush     = 1'b0;
        fifo_wdata     = '{pc: resp_pc_q, instr: imem_resp_data};
        imem_req_valid = 1'b0;
        req_fire       = 1'b0;
        resp_fire      = 1'b0;
        resp_drop      = 1'b0;
        credit_ok      = 1'b0;

        // FIFO occupancy plus in-flight requests never exceeds the FIFO depth.
        credit_ok      = ({1'b0, fifo_count} + {1'b0, outstanding_q}) < SW'(FIFO_DEPTH);
        imem_req_valid = (state_q == ST_FETCH) && !redirect_valid && credit_ok;
        req_fire       = imem_req_valid && imem_req_ready;
        resp_fire      = imem_resp_valid && (outstanding_q != '0);
        resp_drop      = resp_fire && (redirect_valid || (drop_cnt_q != '0));
        fifo_push      = resp_fire && !resp_drop;
        fifo_pop       = out_valid && out_ready && !redirect_valid;
        fifo_flush     = redirect_valid;
        outstanding_d  = outstanding_q + CW'(req_fire) - CW'(resp_fire);

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            drop_cnt_d = outstanding_q - CW'(resp_fire);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + XLEN'(1);
            end
            if (fifo_push) begin
                resp_pc_d = resp_pc_q + XLEN'(1);
            end
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
        end

        if (redirect_valid) begin
            if (drop_cnt_d != '0) begin
                state_d = ST_FLUSH;
            end else begin
                state_d = fetch_enable ? ST_FETCH : ST_IDLE;
            end
        end else begin
            case (state_q)
                ST_IDLE:  state_d = fetch_enable ? ST_FETCH : ST_IDLE;
                ST_FETCH: state_d = fetch_enable ? ST_FETCH : ST_IDLE;
                ST_FLUSH: begin
                    if (drop_cnt_d == '0) begin
                        state_d = fetch_enable ? ST_FETCH : ST_IDLE;
                    end
                end
                default:  state_d = ST_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_dropped_q;
    logic [31:0] perf_stall_q;
    logic [31:0] drop_inc;

    // Drops are stale responses plus whatever the FIFO held when a redirect cleared it.
    assign drop_inc = 32'(resp_drop) + (redirect_valid ? 32'(fifo_count) : 32'd0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_dropped_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            perf_fetched_q <= sat_add32(perf_fetched_q, 32'(fifo_push));
            perf_dropped_q <= sat_add32(perf_dropped_q, drop_inc);
            perf_stall_q   <= sat_add32(perf_stall_q, 32'(out_ready && !out_valid));
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_dropped = perf_dropped_q;
    assign perf_stall   = perf_stall_q;
`endif

`ifndef SYNTHESIS
    a_resp_without_request: assert property (@(posedge clock) disable iff (!reset_n)
        !(imem_resp_valid && (outstanding_q == '0)));
    a_fifo_overflow: assert property (@(posedge clock) disable iff (!reset_n)
        !(fifo_push && fifo_full && !fifo_pop));
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Randomized bench for mips_fetch_unit: in-order variable-latency memory and a
// queue-based reference of the fetch stream, checked every cycle.
module tb_mips_fetch_unit;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] due;
    } mreq_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        fetch_enable;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;
    int unsigned last_due = 0;
    int unsigned lat_min  = 1;
    int unsigned lat_max  = 1;
    int          obs_req  = 0;

    mreq_t       mem_q[$];
    ent_t        m_q[$];
    int          m_inflight = 0;
    int          m_drop     = 0;
    bit          m_fetching = 1'b0;
    logic [31:0] m_next_pc  = 32'h0;

    mips_fetch_unit #(
        .FIFO_DEPTH (DEPTH),
        .RESET_PC   (32'h0)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .fetch_enable    (fetch_enable),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_instr       (out_instr),
        .out_pc          (out_pc)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle: drive inputs at negedge, compare, then advance the reference.
    task automatic step(input logic en, input logic redir, input logic [31:0] rpc,
                        input logic ordy, input logic rdy);
        logic        exp_rv;
        logic        req_fire;
        logic        resp_v;
        mreq_t       rhead;
        ent_t        tmp;
        int unsigned due;
        @(negedge clock);
        fetch_enable   = en;
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = ordy;
        imem_req_ready = rdy;
        resp_v         = (mem_q.size() != 0) && (mem_q[0].due <= cyc);
        imem_resp_valid = resp_v;
        imem_resp_data  = resp_v ? memf(mem_q[0].addr) : 32'h0;
        #1;
        exp_rv = m_fetching && !redir && ((m_q.size() + m_inflight) < int'(DEPTH));
        check_eq("req_valid", 64'(imem_req_valid), 64'(exp_rv));
        if (exp_rv) check_eq("req_addr", 64'(imem_req_addr), 64'(m_next_pc));
        check_eq("out_valid", 64'(out_valid), 64'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check_eq("out_pc", 64'(out_pc), 64'(m_q[0].pc));
            check_eq("out_instr", 64'(out_instr), 64'(m_q[0].instr));
        end
        if (imem_req_valid && rdy) obs_req++;

        req_fire = exp_rv && rdy;
        rhead    = '0;
        if (resp_v) rhead = mem_q.pop_front();
        if (redir) begin
            m_q.delete();
            m_drop    = m_inflight - (resp_v ? 1 : 0);
            m_next_pc = rpc;
        end else begin
            if (ordy && (m_q.size() != 0)) tmp = m_q.pop_front();
            if (resp_v) begin
                if (m_drop > 0) m_drop--;
                else m_q.push_back('{pc: rhead.addr, instr: memf(rhead.addr)});
            end
            if (req_fire) begin
                due = cyc + $urandom_range(lat_max, lat_min);
                if (due <= last_due) due = last_due + 1;
                last_due = due;
                mem_q.push_back('{addr: m_next_pc, due: 32'(due)});
                m_next_pc = m_next_pc + 32'd1;
            end
        end
        m_inflight = m_inflight + (req_fire ? 1 : 0) - (resp_v ? 1 : 0);
        m_fetching = (m_drop == 0) && en;
        cyc++;
    endtask

    task automatic apply_reset(input bit mid_cycle);
        @(negedge clock);
        if (mid_cycle) #2;
        reset_n         = 1'b0;
        fetch_enable    = 1'b0;
        redirect_valid  = 1'b0;
        redirect_pc     = 32'h0;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        out_ready       = 1'b0;
        imem_req_ready  = 1'b0;
        #1;
        check_eq("rst_req_valid", 64'(imem_req_valid), 64'(0));
        check_eq("rst_req_addr", 64'(imem_req_addr), 64'(0));
        check_eq("rst_out_valid", 64'(out_valid), 64'(0));
        check_eq("rst_out_instr", 64'(out_instr), 64'(0));
        check_eq("rst_out_pc", 64'(out_pc), 64'(0));
        repeat (2) @(negedge clock);
        mem_q.delete();
        m_q.delete();
        m_inflight = 0;
        m_drop     = 0;
        m_fetching = 1'b0;
        m_next_pc  = 32'h0;
        last_due   = cyc;
        reset_n    = 1'b1;
    endtask

    initial begin
        logic [31:0] got_pc[3];
        int          n_got;
        bit          found;

        reset_n = 1'b0; fetch_enable = 1'b0; imem_req_ready = 1'b0;
        imem_resp_valid = 1'b0; imem_resp_data = 32'h0; redirect_valid = 1'b0;
        redirect_pc = 32'h0; out_ready = 1'b0;
        apply_reset(1'b0);

        // Single-cycle memory, streaming at one instruction per cycle.
        lat_min = 1; lat_max = 1;
        n_got = 0;
        for (int i = 0; i < 14; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            if (i >= 4 && out_valid) n_got++;
        end
        check_eq("steady_throughput", 64'(n_got), 64'(10));

        // Back-pressure: exactly DEPTH requests, then drain and resume.
        apply_reset(1'b0);
        obs_req = 0;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("stall_req_count", 64'(obs_req), 64'(DEPTH));
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Redirect with two requests in flight on a 3-cycle memory.
        apply_reset(1'b0);
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 10 && m_inflight != 2; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
        check_eq("inflight_before_redir", 64'(m_inflight), 64'(2));
        step(1'b1, 1'b1, 32'h40, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            found = out_valid;
        end
        check_eq("redir_wait", 64'(found), 64'(1));
        check_eq("redir_head_pc", 64'(out_pc), 64'(32'h40));

        // Redirect in the same cycle a response lands, FIFO non-empty, out_ready high.
        apply_reset(1'b0);
        lat_min = 2; lat_max = 2;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            found = (m_q.size() != 0) && (m_inflight >= 2) && (mem_q.size() != 0) && (mem_q[0].due <= cyc);
            if (!found) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        end
        check_eq("resp_redir_setup", 64'(found), 64'(1));
        step(1'b1, 1'b1, 32'h100, 1'b1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            found = out_valid;
        end
        check_eq("resp_redir_wait", 64'(found), 64'(1));
        check_eq("resp_redir_head", 64'(out_pc), 64'(32'h100));

        // PC wrap across 2^32.
        apply_reset(1'b0);
        lat_min = 1; lat_max = 1;
        step(1'b1, 1'b1, 32'hFFFF_FFFE, 1'b1, 1'b1);
        n_got = 0;
        for (int i = 0; i < 30 && n_got < 3; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);
            if (out_valid) begin
                got_pc[n_got] = out_pc;
                n_got++;
            end
        end
        check_eq("wrap_count", 64'(n_got), 64'(3));
        check_eq("wrap_pc0", 64'(got_pc[0]), 64'(32'hFFFF_FFFE));
        check_eq("wrap_pc1", 64'(got_pc[1]), 64'(32'hFFFF_FFFF));
        check_eq("wrap_pc2", 64'(got_pc[2]), 64'(32'h0));

        // Asynchronous reset mid-stream with requests outstanding.
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        check_eq("pre_reset_valid", 64'(out_valid), 64'(1));
        apply_reset(1'b1);
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b1, 1'b1);

        // Randomized traffic against the reference.
        for (int blk = 0; blk < 15; blk++) begin
            lat_min = $urandom_range(2, 1);
            lat_max = lat_min + $urandom_range(3, 0);
            if (blk == 7) apply_reset(1'b1);
            for (int i = 0; i < 200; i++) begin
                logic        r_en, r_rd, r_ordy, r_rdy;
                logic [31:0] r_pc;
                r_en   = ($urandom_range(9, 0) != 0);
                r_rd   = ($urandom_range(19, 0) == 0);
                r_pc   = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 + 32'($urandom_range(15, 0))) : 32'($urandom);
                r_ordy = ($urandom_range(3, 0) != 0);
                r_rdy  = ($urandom_range(3, 0) != 0);
                step(r_en, r_rd, r_pc, r_ordy, r_rdy);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- Instruction-fetch front end that sits directly upstream of the MIPS core's decode/execute stage.
- Generates word-addressed PCs and issues requests to instruction memory, which may have variable latency.
- Buffers returned words with their PCs in a small prefetch FIFO and presents them to the core over a valid/ready handshake.
- Accepts jump/branch/jump-register redirects from the core and flushes the FIFO and any stale in-flight responses.

Parameters:
- FIFO_DEPTH, default 4: prefetch entries; power of two, at least 2; also the maximum number of in-flight memory requests.
- RESET_PC, default 32'h0: fetch PC loaded at reset.

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_enable  in  1  permits new requests to be issued.
- imem_req_valid  out  1  request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  32  word address (PC).
- imem_resp_valid  in  1  response word valid; responses return in order, at least 1 cycle after acceptance.
- imem_resp_data  in  32  instruction word.
- redirect_valid  in  1  one-cycle pulse from the core: taken branch, jump or jr.
- redirect_pc  in  32  new PC, word-addressed.
- out_valid  out  1  instruction available.
- out_ready  in  1  core consumes the instruction.
- out_instr  out  32  instruction.
- out_pc  out  32  PC of out_instr.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; fetch_pc=RESET_PC; resp_pc=RESET_PC.
  - FIFO empty; outstanding=0; drop_cnt=0.
  - imem_req_valid=0; out_valid=0; out_instr=0; out_pc=0.
- State machine (IDLE, FETCH, FLUSH):
  - IDLE->FETCH when fetch_enable=1.
  - FETCH->IDLE when fetch_enable=0. Responses already in flight still land in the FIFO.
  - Any state with redirect_valid=1 -> FLUSH if the computed drop_cnt is greater than 0, else -> FETCH (-> IDLE if fetch_enable=0).
  - FLUSH->FETCH (or IDLE) on the cycle drop_cnt reaches 0.
- Issue rule:
  - imem_req_valid = (state==FETCH) && !redirect_valid && (fifo_count+outstanding < FIFO_DEPTH).
  - imem_req_addr = fetch_pc.
  - On handshake: fetch_pc <= fetch_pc+1, modulo 2^32 (0xFFFFFFFF wraps to 0); outstanding increments.
- Response:
  - Each imem_resp_valid decrements outstanding.
  - If drop_cnt>0: the response is discarded and drop_cnt decrements.
  - Otherwise: {resp_pc, data} is pushed to the FIFO and resp_pc increments (mod 2^32).
  - A response with outstanding==0 is ignored; flagged by a simulation-only assertion.
- Output:
  - out_valid = FIFO not empty; out_instr/out_pc show the FIFO head.
  - Pop on out_valid && out_ready.
  - Zero-cycle bypass is not allowed: a response becomes visible the cycle after it arrives.
  - Throughput is 1 instruction/cycle at steady state.
- Redirect, same cycle:
  - FIFO cleared; fetch_pc and resp_pc <= redirect_pc.
  - drop_cnt <= outstanding minus (1 if a response arrives this cycle). A response arriving in the redirect cycle is itself discarded.
  - The output entry presented in that cycle is discarded whether or not out_ready is high.
  - No request is issued that cycle.
- Simultaneous push and pop on a full FIFO is legal. Overflow is impossible by the credit rule; guarded by an assertion.
- A second redirect during FLUSH reloads the PCs and recomputes drop_cnt using the same rule.

Optional Feature:
- Macro FETCH_PERF_EN.
- When defined, adds output ports perf_fetched (32), perf_dropped (32) and perf_stall (32):
  - perf_fetched counts FIFO pushes.
  - perf_dropped counts discarded responses plus FIFO entries flushed by redirects.
  - perf_stall counts cycles with out_ready=1 && out_valid=0.
  - All three are cleared by reset and saturate at all-ones.
- When not defined, these ports and counters are absent and the behaviour is otherwise identical.

Decomposition:
- Package mips_fetch_pkg holds: the state encoding (IDLE, FETCH, FLUSH), the RESET_PC default, and the FIFO entry type {pc[31:0], instr[31:0]}.
- Sub-module fetch_fifo: synchronous FIFO with parameter DEPTH, push/pop/flush inputs, count, full/empty, and async active-low reset.

Test Plan:
- Reset, fetch_enable=1, 1-cycle memory, out_ready=1 -> requests at addresses 0,1,2,...; out_pc 0,1,2 back-to-back, one per cycle.
- out_ready=0 with FIFO_DEPTH=4 -> exactly 4 requests issued, then imem_req_valid=0. Raising out_ready -> PCs 0..3 drain in order and issue resumes at PC 4.
- 3-cycle memory latency, redirect to 0x40 while 2 requests are in flight -> both responses dropped; the next out_pc is 0x40 and the FIFO holds no stale entries.
- Redirect in the same cycle a response arrives and out_ready=1 with FIFO non-empty -> FIFO flushed; drop_cnt = outstanding-1; first output is redirect_pc.
- Start with fetch_pc=0xFFFFFFFE -> out_pc sequence 0xFFFFFFFE, 0xFFFFFFFF, 0x0.
- reset_n asserted mid-stream with 2 requests outstanding -> all outputs 0 immediately (async). After release, fetch restarts at RESET_PC and out_valid=0 until the first new response.
